// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: per-character sprite frame sequencer, advancing once per vsync rising edge.
//   Clk       - system clock
//   Reset     - asynchronous active-high reset
//   vsync     - VGA vsync level, synchronous to Clk
//   vel_x     - signed horizontal velocity (two's complement, VEL_W bits)
//   on_ground - character standing on a surface
//   dead      - character killed
//   frame_sel - 0 idle, 1 walk1, 2 walk2, 3 jump, 4 dead, 5 skid
//   flip      - mirror horizontally (facing left)
//   anim_tick - one-cycle pulse on each accepted frame tick
// Optional macro SKID_ANIM_EN adds a one-tick skid frame on walking direction reversal.
module sprite_anim_ctrl #(
    parameter int WALK_DIV   = 8,
    parameter int RUN_THRESH = 4,
    parameter int VEL_W      = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             vsync,
    input  logic [VEL_W-1:0] vel_x,
    input  logic             on_ground,
    input  logic             dead,
    output logic [2:0]       frame_sel,
    output logic             flip,
    output logic             anim_tick
);
    localparam int CW = $clog2(WALK_DIV + 1);
`ifdef SKID_ANIM_EN
    typedef enum logic [2:0] {IDLE = 3'd0, WALK1 = 3'd1, WALK2 = 3'd2, JUMP = 3'd3, DEAD = 3'd4, SKID = 3'd5} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, WALK1 = 3'd1, WALK2 = 3'd2, JUMP = 3'd3, DEAD = 3'd4} state_t;
`endif
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flip_q, flip_d;
    logic            vsync_q, vsync_q2;
    logic            tick, neg, nz, walking, wrap, flip_upd;
    logic [VEL_W:0]  vel_ext, vel_abs;
    logic [CW-1:0]   lim_m1;
    assign tick     = vsync_q & ~vsync_q2;
    assign neg      = vel_x[VEL_W-1];
    assign nz       = |vel_x;
    // one extra bit so the most negative velocity has a representable magnitude
    assign vel_ext  = {vel_x[VEL_W-1], vel_x};
    assign vel_abs  = neg ? -vel_ext : vel_ext;
    assign lim_m1   = (vel_abs < (VEL_W+1)'(RUN_THRESH)) ? CW'(WALK_DIV - 1) : CW'(WALK_DIV / 2 - 1);
    assign walking  = (state_q == WALK1) || (state_q == WALK2);
    // >= also catches a counter left above a freshly shortened run limit
    assign wrap     = cnt_q >= lim_m1;
    assign flip_upd = neg ? 1'b1 : nz ? 1'b0 : flip_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flip_d  = flip_q;
        if (tick) begin
            cnt_d = '0;
            if (dead || state_q == DEAD) begin
                state_d = DEAD;
            end else begin
                flip_d = flip_upd;
                if (!on_ground) state_d = JUMP;
                else if (!nz) state_d = IDLE;
`ifdef SKID_ANIM_EN
                else if (walking && (neg != flip_q)) begin
                    state_d = SKID;
                    flip_d  = flip_q;
                end
`endif
                else if (walking) begin
                    state_d = wrap ? ((state_q == WALK1) ? WALK2 : WALK1) : state_q;
                    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
                end
                else state_d = WALK1;
            end
        end
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            flip_q   <= 1'b0;
            vsync_q  <= 1'b0;
            vsync_q2 <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flip_q   <= flip_d;
            vsync_q  <= vsync;
            vsync_q2 <= vsync_q;
        end
    end
    assign frame_sel = state_q;
    assign flip      = flip_q;
    assign anim_tick = tick;
endmodule
